bin2bcd_scan: RTL and testbench
===============================

Name: bin2bcd_scan

Overview:
- Upstream feeder for the BCD-to-7-segment decoder in the display path.
- Accepts a binary value and converts it to DIGITS packed BCD digits with a sequential double-dabble (shift-add-3) engine.
- Holds the result in display registers and time-multiplexes the digits onto a single 4-bit bcd bus with matching active-low digit-enable (anode) lines.
- The decoder consumes bcd; the board consumes an.

Parameters:
- DIGITS, 4: number of display digits; digit 0 is least significant (rightmost).
- WIDTH, 14: width of the binary input value.
- SCAN_DIV, 50000: clock cycles each digit stays active; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load  in  1  single-cycle request to convert value; sampled only when busy=0.
- value  in  WIDTH  unsigned binary value to display.
- busy  out  1  high while a conversion is in progress.
- bcd  out  4  BCD digit for the currently active position; values 10..15 render as dash downstream.
- an  out  DIGITS  active-low one-hot digit enable.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous, active-low. All registers change only on clk rising edge.
- Reset values:
  - busy=0, bcd=4'h0, an=all ones, all display digits=0.
  - Scan index=0, prescaler=0, FSM=IDLE, overflow flag=0.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - load=1 at edge E0 latches value into the shift register, clears the BCD accumulator and overflow flag, clears the shift counter, and moves to SHIFT.
  - busy=1 after E0.
- SHIFT, one bit per cycle, edges E1..E_WIDTH:
  - First, each accumulator nibble >= 5 gets +3.
  - Then {accumulator, shift register} shifts left by 1.
  - A 1 shifted out of the top nibble sets the sticky overflow flag.
  - After WIDTH shifts, move to COMMIT.
- COMMIT, edge E_WIDTH+1:
  - All display digits are written atomically: accumulator nibbles, or 4'hF in every digit if overflow is set.
  - FSM returns to IDLE and busy=0.
  - busy is high for exactly WIDTH+1 cycles.
  - The display changes once, never partially.
- Load handling:
  - load while busy=1 is ignored, with no queueing.
  - load in the first cycle busy=0 is accepted.
  - value is sampled only at acceptance; later changes to value have no effect.
- Overflow:
  - Any value > 10^DIGITS-1 displays all 4'hF.
  - value = 10^DIGITS-1 displays normally.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps every cycle regardless of FSM state.
  - On wrap, the scan index advances by 1 modulo DIGITS (DIGITS-1 -> 0).
- Output registration:
  - bcd and an are registered from the current scan index and display digits; 1-cycle lag from index.
  - an = ~(1 << index).
  - First enabled pattern appears one edge after reset release.
- Reset mid-conversion:
  - Aborts the conversion, display returns to 0, busy=0 on the next cycle.
  - A load asserted with rst_n=0 is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Any digit above the most significant nonzero digit is blanked: its an bit is held high while it is the scan index; bcd still carries 0.
  - Digit 0 is never blanked, so value 0 shows "0".
  - In overflow, nothing is blanked.
  - The blank mask is computed at COMMIT and stored with the display digits.
- When undefined: all DIGITS positions are always enabled in turn, and leading zeros are shown.

Test Plan (DIGITS=4, WIDTH=14, SCAN_DIV=4):
- Reset hold 3 cycles, release -> busy=0, an=4'b1111 during reset, an=4'b1110 with bcd=0 one cycle after release; an steps 1110->1101->1011->0111->1110 every 4 cycles.
- load with value=1234 -> busy high exactly 15 cycles; then bcd=4,3,2,1 when an=1110,1101,1011,0111 respectively.
- value=9999 -> digits 9,9,9,9; value=10000 -> bcd=4'hF at every position; value=0 -> all digits 0.
- Conversion of 1234 completes, then load value=5678 and pulse load again 5 cycles later (value=1111) -> second load ignored, display 5678 after 15 cycles; load in first cycle after busy falls is accepted.
- Start value=4321, drive rst_n=0 at cycle 7 of SHIFT -> busy=0, display digits 0, an=4'b1111 during reset; no later COMMIT occurs.
- With LEADING_ZERO_BLANK_EN, value=42 -> an stays 1111 while index is 2 or 3, and bcd=2,4 at index 0,1; value=0 -> only digit 0 enabled, showing 0.

Source files
------------

// File: rtl/bin2bcd_scan_if.sv
// Load/status and scanned display bus between a value source, the bin2bcd_scan
// converter and the downstream 7-segment decoder and anode drivers.
interface bin2bcd_scan_if #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
);
   logic              load;
   logic [WIDTH-1:0]  value;
   logic              busy;
   logic [3:0]        bcd;
   logic [DIGITS-1:0] an;

   modport master (output load, value, input busy, bcd, an);
   modport slave  (input load, value, output busy, bcd, an);
endinterface

// File: rtl/bin2bcd_scan.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed digit scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the anodes of leading zero digits.
module bin2bcd_scan #(
   parameter int DIGITS   = 4,
   parameter int WIDTH    = 14,
   parameter int SCAN_DIV = 50000
) (
   input logic            clk,
   input logic            rst_n,
   bin2bcd_scan_if.slave  bus
);
   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t          state, state_nx;
   logic            accept, shift_en, commit_en;
   logic [WIDTH-1:0] sreg;
   logic [AW-1:0]   acc, acc_adj;
   logic            ovf;
   logic [CW-1:0]   cnt;
   logic            last_shift;
   logic [3:0]      disp [DIGITS];
   logic [PW-1:0]   presc;
   logic [IW-1:0]   idx;
`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank, blank_nx;
`endif

   function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
      logic [AW-1:0] r;
      r = a;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign acc_adj    = add3(acc);
   assign last_shift = (cnt == CW'(WIDTH - 1));
   assign bus.busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      shift_en  = 1'b0;
      commit_en = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load) begin
               accept   = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last_shift) state_nx = COMMIT;
         end
         COMMIT: begin
            commit_en = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // conversion engine: add-3 correction precedes each left shift
   always_ff @(posedge clk) begin
      if (accept) begin
         sreg <= bus.value;
         acc  <= '0;
      end else if (shift_en) begin
         acc  <= {acc_adj[AW-2:0], sreg[WIDTH-1]};
         sreg <= sreg << 1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
         cnt <= '0;
      end else if (accept) begin
         ovf <= 1'b0;
         cnt <= '0;
      end else if (shift_en) begin
         ovf <= ovf | acc_adj[AW-1];
         cnt <= cnt + CW'(1);
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // a digit is blank when it and every digit above it are zero; digit 0 always shows
   always_comb begin
      logic seen;
      seen     = 1'b0;
      blank_nx = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         seen        = seen | (acc[4*i +: 4] != 4'd0);
         blank_nx[i] = !seen && !ovf;
      end
   end
`endif

   // display registers: whole result written in one edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) disp[i] <= 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
         blank <= '0;
`endif
      end else if (commit_en) begin
         for (int i = 0; i < DIGITS; i++) disp[i] <= ovf ? 4'hF : acc[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
         blank <= blank_nx;
`endif
      end
   end

   // scan prescaler and digit index run independently of the converter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // output stage: one edge behind the scan index
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.bcd <= 4'h0;
         bus.an  <= '1;
      end else begin
         bus.bcd <= disp[idx];
`ifdef LEADING_ZERO_BLANK_EN
         bus.an  <= blank[idx] ? '1 : ~(DIGITS'(1) << idx);
`else
         bus.an  <= ~(DIGITS'(1) << idx);
`endif
      end
   end
endmodule

// File: tb/tb_bin2bcd_scan.sv
// Self-checking bench for bin2bcd_scan: table of conversions plus hand-written
// sequences for ignored loads, back-to-back acceptance and reset mid-conversion.
module tb_bin2bcd_scan;
   localparam int DIGITS   = 4;
   localparam int WIDTH    = 14;
   localparam int SCAN_DIV = 4;
   localparam int BUSY_CYC = WIDTH + 1;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   typedef struct {int v; logic [15:0] digits;} vec_t;
   typedef struct {logic [15:0] digits; logic [3:0] blank;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t tbl[8];

   always #5 clk = ~clk;

   bin2bcd_scan_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

   bin2bcd_scan #(.DIGITS(DIGITS), .WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] model_blank(input int v);
      logic [3:0] m;
      m = '0;
      if (BLANK_EN && v <= 9999) begin
         if (v < 10)   m[1] = 1'b1;
         if (v < 100)  m[2] = 1'b1;
         if (v < 1000) m[3] = 1'b1;
      end
      return m;
   endfunction

   // drive load for one edge; the value is scrambled right after acceptance
   task automatic start(input int v, input logic [15:0] digits, input bit push);
      exp_t e;
      bus.value = WIDTH'(v);
      bus.load  = 1'b1;
      if (push) begin
         e.digits = digits;
         e.blank  = model_blank(v);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.load  = 1'b0;
      bus.value = WIDTH'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_display(input string tag);
      exp_t       e;
      bit         seen [4];
      logic [3:0] got  [4];
      int         zeros;
      bit         shape_ok;
      shape_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         seen[i] = 1'b0;
         got[i]  = 4'h0;
      end
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 0, 1);
         return;
      end
      e = sb.pop_front();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         zeros = 0;
         for (int i = 0; i < 4; i++) begin
            if (bus.an[i] === 1'b0) begin
               zeros++;
               seen[i] = 1'b1;
               got[i]  = bus.bcd;
            end
         end
         if (zeros > 1) shape_ok = 1'b0;
      end
      chk({tag, "_an_onehot"}, shape_ok, 1);
      for (int i = 0; i < 4; i++) begin
         if (e.blank[i]) begin
            chk($sformatf("%s_blank%0d", tag, i), seen[i], 0);
         end else begin
            chk($sformatf("%s_en%0d", tag, i), seen[i], 1);
            chk($sformatf("%s_dig%0d", tag, i), got[i], e.digits[4*i +: 4]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         n, m;
      logic [3:0] exp_an;
      exp_t       e;

      tbl[0] = '{1234,  16'h1234};
      tbl[1] = '{9999,  16'h9999};
      tbl[2] = '{10000, 16'hFFFF};
      tbl[3] = '{0,     16'h0000};
      tbl[4] = '{42,    16'h0042};
      tbl[5] = '{16383, 16'hFFFF};
      tbl[6] = '{1,     16'h0001};
      tbl[7] = '{9000,  16'h9000};

      bus.load  = 1'b0;
      bus.value = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_an", bus.an, 4'hF);
      chk("rst_bcd", bus.bcd, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         exp_an = ~(4'b0001 << ((k / 4) % 4));
         chk($sformatf("scan_an%0d", k), bus.an, exp_an);
         if (k == 0) chk("scan_bcd0", bus.bcd, 0);
      end

      for (int t = 0; t < 8; t++) begin
         start(tbl[t].v, tbl[t].digits, 1'b1);
         wait_done(n);
         chk($sformatf("busy_cycles_%0d", tbl[t].v), n, BUSY_CYC);
         check_display($sformatf("v%0d", tbl[t].v));
      end

      // load while busy is dropped
      start(5678, 16'h5678, 1'b1);
      n = 0;
      repeat (5) begin
         if (bus.busy === 1'b1) n++;
         @(negedge clk);
      end
      bus.value = WIDTH'(1111);
      bus.load  = 1'b1;
      if (bus.busy === 1'b1) n++;
      @(negedge clk);
      bus.load = 1'b0;
      wait_done(m);
      chk("ignored_busy_cycles", n + m, BUSY_CYC);
      check_display("v5678");

      // load in the first idle cycle is taken
      start(4444, 16'h4444, 1'b0);
      wait_done(n);
      chk("b2b_first_busy", n, BUSY_CYC);
      start(2468, 16'h2468, 1'b1);
      chk("accept_first_idle", bus.busy, 1);
      wait_done(n);
      chk("b2b_second_busy", n, BUSY_CYC);
      check_display("v2468");

      // reset in the middle of a conversion
      start(4321, 16'h4321, 1'b0);
      repeat (6) @(negedge clk);
      rst_n     = 1'b0;
      bus.load  = 1'b1;
      bus.value = WIDTH'(77);
      @(negedge clk);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_an", bus.an, 4'hF);
      chk("midrst_bcd", bus.bcd, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      bus.load = 1'b0;
      @(negedge clk);
      chk("load_in_reset_discarded", bus.busy, 0);
      e.digits = 16'h0000;
      e.blank  = 4'h0;
      sb.push_back(e);
      check_display("after_reset");
      chk("no_late_commit", bus.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
